// File: rtl/ysyx_23060059_pkg.sv
// Shared LSU types: FSM state encoding, load-width masks, pass-through bundle
// and the alignment rule used when YSYX_23060059_LSU_MISALIGN_CHECK_EN is defined.
package ysyx_23060059_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    SEND = 2'd3
  } lsu_state_e;

  localparam logic [31:0] MASK_BYTE = 32'h0000_00FF;
  localparam logic [31:0] MASK_HALF = 32'h0000_FFFF;
  localparam logic [31:0] MASK_WORD = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [4:0]  rd;
    logic [1:0]  csr_rd;
    logic [1:0]  wdop;
    logic        csrwdop;
    logic        reg_write_en;
    logic        csreg_write_en;
    logic        ecall;
  } lsu_pass_t;

  // Access width comes from the byte strobe for stores and the read mask for loads.
  function automatic logic is_misaligned(input logic        is_store,
                                         input logic [3:0]  wmask,
                                         input logic [31:0] rmask,
                                         input logic [1:0]  off);
    logic half;
    logic word;
    half = is_store ? (wmask == 4'b0011) : (rmask == MASK_HALF);
    word = is_store ? (wmask == 4'b1111) : (rmask == MASK_WORD);
    return (half && off[0]) || (word && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the read word down by the byte offset, masks it to
// the access width and optionally sign-extends from the top bit of the mask.
module lsu_load_align
  import ysyx_23060059_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [31:0] rmask,
  input  logic        is_signed,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [31:0] masked;
  logic [31:0] fill;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    masked  = shifted & rmask;
    fill    = '0;
    if (rmask[31])      fill = ~MASK_WORD;
    else if (rmask[15]) fill = masked[15] ? ~MASK_HALF : '0;
    else if (rmask[7])  fill = masked[7]  ? ~MASK_BYTE : '0;
    data = is_signed ? (masked | fill) : masked;
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: takes one EXU op at a time, issues at most one memory request
// and hands the result to WBU. YSYX_23060059_LSU_MISALIGN_CHECK_EN enables misalignment faults.
module lsu
  import ysyx_23060059_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_receive_valid,
  output logic        lsu_send_ready,
  output logic        lsu_send_valid,
  input  logic        lsu_receive_ready,
  input  logic [31:0] alu_result_input,
  input  logic [31:0] wdata_input,
  input  logic        ren_input,
  input  logic        wen_input,
  input  logic [7:0]  wmask_input,
  input  logic [31:0] rmask_input,
  input  logic        memory_read_signed_input,
  input  logic [31:0] pc_input,
  input  logic [31:0] pc_next_input,
  input  logic [4:0]  rd_input,
  input  logic [1:0]  csr_rd_input,
  input  logic [1:0]  wdOp_input,
  input  logic        csrwdOp_input,
  input  logic        reg_write_en_input,
  input  logic        csreg_write_en_input,
  input  logic        ecall_input,
  output logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic [4:0]  rd,
  output logic [1:0]  csr_rd,
  output logic [1:0]  wdOp,
  output logic        csrwdOp,
  output logic        reg_write_en,
  output logic        csreg_write_en,
  output logic        ecall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] result,
  output logic        lsu_fault
);

  lsu_state_e  state_q, state_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic        load_q, load_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] rmask_q, rmask_d;
  logic        signed_q, signed_d;
  logic [31:0] result_q, result_d;
  lsu_pass_t   pass_q, pass_d;

  logic        accept;
  logic        mem_op;
  logic        fault_in;
  logic [31:0] load_data;
  logic        unused_wmask_hi;

  assign unused_wmask_hi = ^wmask_input[7:4];
  assign accept = (state_q == IDLE) && lsu_receive_valid;
  assign mem_op = ren_input || wen_input;

`ifdef YSYX_23060059_LSU_MISALIGN_CHECK_EN
  logic fault_q, fault_d;

  assign fault_in = mem_op && is_misaligned(wen_input, wmask_input[3:0], rmask_input,
                                            alu_result_input[1:0]);

  always_comb begin
    fault_d = fault_q;
    if (accept) fault_d = fault_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault_q <= 1'b0;
    else      fault_q <= fault_d;
  end

  assign lsu_fault = fault_q;
`else
  assign fault_in  = 1'b0;
  assign lsu_fault = 1'b0;
`endif

  lsu_load_align u_load_align (
    .rdata     (mem_rdata),
    .off       (alu_q[1:0]),
    .rmask     (rmask_q),
    .is_signed (signed_q),
    .data      (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Faulting ops skip the memory phases and report straight to WBU.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (lsu_receive_valid) state_d = (mem_op && !fault_in) ? REQ : SEND;
      REQ:     if (mem_req_ready)     state_d = RESP;
      RESP:    if (mem_resp_valid)    state_d = SEND;
      SEND:    if (lsu_receive_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lsu_send_ready = 1'b0;
    lsu_send_valid = 1'b0;
    mem_req_valid  = 1'b0;
    mem_addr       = '0;
    mem_wen        = 1'b0;
    mem_wdata      = '0;
    mem_wstrb      = '0;
    case (state_q)
      IDLE: lsu_send_ready = rst;
      REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = {alu_q[31:2], 2'b00};
        mem_wen       = wen_q;
        mem_wdata     = wdata_q << {alu_q[1:0], 3'b000};
        mem_wstrb     = wmask_q << alu_q[1:0];
      end
      SEND:    lsu_send_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    alu_d    = alu_q;
    wdata_d  = wdata_q;
    wen_d    = wen_q;
    load_d   = load_q;
    wmask_d  = wmask_q;
    rmask_d  = rmask_q;
    signed_d = signed_q;
    result_d = result_q;
    pass_d   = pass_q;
    if (accept) begin
      alu_d    = alu_result_input;
      wdata_d  = wdata_input;
      wen_d    = wen_input;
      load_d   = ren_input && !wen_input;
      wmask_d  = wmask_input[3:0];
      rmask_d  = rmask_input;
      signed_d = memory_read_signed_input;
      result_d = alu_result_input;
      pass_d   = '{pc: pc_input, pc_next: pc_next_input, rd: rd_input,
                   csr_rd: csr_rd_input, wdop: wdOp_input, csrwdop: csrwdOp_input,
                   reg_write_en: reg_write_en_input && !fault_in,
                   csreg_write_en: csreg_write_en_input, ecall: ecall_input};
    end else if ((state_q == RESP) && mem_resp_valid && load_q) begin
      result_d = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q    <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      load_q   <= 1'b0;
      wmask_q  <= '0;
      rmask_q  <= '0;
      signed_q <= 1'b0;
      result_q <= '0;
      pass_q   <= '0;
    end else begin
      alu_q    <= alu_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      load_q   <= load_d;
      wmask_q  <= wmask_d;
      rmask_q  <= rmask_d;
      signed_q <= signed_d;
      result_q <= result_d;
      pass_q   <= pass_d;
    end
  end

  assign result         = result_q;
  assign pc             = pass_q.pc;
  assign pc_next        = pass_q.pc_next;
  assign rd             = pass_q.rd;
  assign csr_rd         = pass_q.csr_rd;
  assign wdOp           = pass_q.wdop;
  assign csrwdOp        = pass_q.csrwdop;
  assign reg_write_en   = pass_q.reg_write_en;
  assign csreg_write_en = pass_q.csreg_write_en;
  assign ecall          = pass_q.ecall;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus random ops checked against an
// arithmetic reference model; honours YSYX_23060059_LSU_MISALIGN_CHECK_EN.
module tb_lsu;

  localparam int K_ALU = 0, K_LB = 1, K_LBU = 2, K_LH = 3, K_LHU = 4, K_LW = 5;
  localparam int K_SB = 6, K_SH = 7, K_SW = 8, K_SRW = 9;

`ifdef YSYX_23060059_LSU_MISALIGN_CHECK_EN
  localparam bit MISALIGN_CHK = 1'b1;
`else
  localparam bit MISALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_receive_valid, lsu_send_ready, lsu_send_valid, lsu_receive_ready;
  logic [31:0] alu_result_input, wdata_input, rmask_input;
  logic        ren_input, wen_input, memory_read_signed_input;
  logic [7:0]  wmask_input;
  logic [31:0] pc_input, pc_next_input;
  logic [4:0]  rd_input;
  logic [1:0]  csr_rd_input, wdOp_input;
  logic        csrwdOp_input, reg_write_en_input, csreg_write_en_input, ecall_input;
  logic [31:0] pc, pc_next;
  logic [4:0]  rd;
  logic [1:0]  csr_rd, wdOp;
  logic        csrwdOp, reg_write_en, csreg_write_en, ecall;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, result;
  logic [3:0]  mem_wstrb;
  logic        lsu_fault;

  int errors = 0;
  int checks = 0;

  logic        last_req_seen, last_fault;
  logic [31:0] last_addr, last_wdata, last_result;
  logic [3:0]  last_wstrb;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst),
    .lsu_receive_valid(lsu_receive_valid), .lsu_send_ready(lsu_send_ready),
    .lsu_send_valid(lsu_send_valid), .lsu_receive_ready(lsu_receive_ready),
    .alu_result_input(alu_result_input), .wdata_input(wdata_input),
    .ren_input(ren_input), .wen_input(wen_input), .wmask_input(wmask_input),
    .rmask_input(rmask_input), .memory_read_signed_input(memory_read_signed_input),
    .pc_input(pc_input), .pc_next_input(pc_next_input), .rd_input(rd_input),
    .csr_rd_input(csr_rd_input), .wdOp_input(wdOp_input), .csrwdOp_input(csrwdOp_input),
    .reg_write_en_input(reg_write_en_input), .csreg_write_en_input(csreg_write_en_input),
    .ecall_input(ecall_input),
    .pc(pc), .pc_next(pc_next), .rd(rd), .csr_rd(csr_rd), .wdOp(wdOp), .csrwdOp(csrwdOp),
    .reg_write_en(reg_write_en), .csreg_write_en(csreg_write_en), .ecall(ecall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .result(result), .lsu_fault(lsu_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {26'b0, lsu_send_ready, lsu_send_valid, mem_req_valid, mem_wen, lsu_fault,
              reg_write_en}, 32'h0);
    chk(tag, mem_addr | mem_wdata | result | pc | pc_next, 32'h0);
    chk(tag, {16'b0, rd, csr_rd, wdOp, csrwdOp, csreg_write_en, ecall, mem_wstrb}, 32'h0);
  endtask

  // Loaded value from the byte offset and width, using integer arithmetic.
  function automatic logic [31:0] ref_load(input int kind, input logic [31:0] addr,
                                           input logic [31:0] data);
    longint v;
    int     off;
    off = int'(addr[1:0]);
    v   = longint'(data) / (longint'(1) << (8 * off));
    case (kind)
      K_LB:    begin v = v % 256;   if (v > 127)   v = v - 256;   end
      K_LBU:   v = v % 256;
      K_LH:    begin v = v % 65536; if (v > 32767) v = v - 65536; end
      K_LHU:   v = v % 65536;
      default: ;
    endcase
    return v[31:0];
  endfunction

  task automatic scramble_inputs();
    alu_result_input = $urandom;  wdata_input = $urandom;  rmask_input = $urandom;
    ren_input = 1'($urandom);     wen_input = 1'($urandom); wmask_input = 8'($urandom);
    memory_read_signed_input = 1'($urandom);
    pc_input = $urandom;  pc_next_input = $urandom;  rd_input = 5'($urandom);
    csr_rd_input = 2'($urandom);  wdOp_input = 2'($urandom);  csrwdOp_input = 1'($urandom);
    reg_write_en_input = 1'($urandom);  csreg_write_en_input = 1'($urandom);
    ecall_input = 1'($urandom);
  endtask

  // Runs one op from an IDLE negedge to the IDLE negedge after WBU takes it.
  task automatic run_op(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdat, input int req_stall, input int resp_stall,
                        input int send_stall);
    logic        is_load, is_store, half, word, exp_fault, exp_mem;
    logic [3:0]  wm, exp_wstrb;
    logic [31:0] exp_result, exp_wdata, exp_pc, exp_pcn;
    logic [12:0] exp_misc;
    int          off;
    is_load  = (kind >= K_LB) && (kind <= K_LW);
    is_store = (kind >= K_SB);
    case (kind)
      K_SB:    wm = 4'h1;
      K_SH:    wm = 4'h3;
      K_SW:    wm = 4'hF;
      K_SRW:   case ($urandom_range(0, 2)) 0: wm = 4'h1; 1: wm = 4'h3; default: wm = 4'hF; endcase
      default: wm = 4'($urandom);
    endcase
    half = (kind == K_LH) || (kind == K_LHU) || (is_store && wm == 4'h3);
    word = (kind == K_LW) || (is_store && wm == 4'hF);
    exp_fault = MISALIGN_CHK && ((half && addr[0]) || (word && addr[1:0] != 2'b00));
    exp_mem   = (is_load || is_store) && !exp_fault;
    exp_result = (is_load && !exp_fault) ? ref_load(kind, addr, rdat) : addr;
    off = int'(addr[1:0]);
    exp_wdata = '0;
    exp_wstrb = '0;
    for (int lane = 0; lane < 4; lane++) begin
      if (lane >= off) begin
        exp_wdata[lane*8 +: 8] = wd[(lane-off)*8 +: 8];
        exp_wstrb[lane]        = wm[lane-off];
      end
    end

    scramble_inputs();
    alu_result_input = addr;
    wdata_input      = wd;
    ren_input        = is_load || (kind == K_SRW);
    wen_input        = is_store;
    wmask_input      = {4'($urandom), wm};
    rmask_input      = (kind == K_LB || kind == K_LBU) ? 32'h0000_00FF :
                       (kind == K_LH || kind == K_LHU) ? 32'h0000_FFFF :
                       (kind == K_LW) ? 32'hFFFF_FFFF : $urandom;
    memory_read_signed_input = (kind == K_LB || kind == K_LH) ? 1'b1 :
                               (kind == K_LBU || kind == K_LHU) ? 1'b0 : 1'($urandom);
    exp_pc   = pc_input;
    exp_pcn  = pc_next_input;
    exp_misc = {rd_input, csr_rd_input, wdOp_input, csrwdOp_input,
                reg_write_en_input && !exp_fault, csreg_write_en_input, ecall_input};

    chk("idle_ready", lsu_send_ready, 1'b1);
    lsu_receive_valid = 1'b1;
    mem_req_ready     = 1'($urandom);
    mem_resp_valid    = 1'($urandom);
    @(negedge clk);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    scramble_inputs();
    lsu_receive_valid = 1'($urandom);
    last_req_seen = mem_req_valid;
    last_addr     = mem_addr;
    last_wdata    = mem_wdata;
    last_wstrb    = mem_wstrb;
    chk("busy_ready", lsu_send_ready, 1'b0);

    if (exp_mem) begin
      for (int i = 0; i <= req_stall; i++) begin
        if (i > 0) @(negedge clk);
        chk("req_valid", mem_req_valid, 1'b1);
        chk("req_addr", mem_addr, {addr[31:2], 2'b00});
        chk("req_wen", mem_wen, is_store);
        if (is_store) begin
          chk("req_wdata", mem_wdata, exp_wdata);
          chk("req_wstrb", mem_wstrb, exp_wstrb);
        end
        mem_resp_valid = 1'($urandom);
        lsu_receive_valid = 1'($urandom);
      end
      mem_resp_valid = 1'b0;
      mem_req_ready  = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk("resp_noreq", mem_req_valid, 1'b0);
      for (int i = 0; i < resp_stall; i++) begin
        mem_req_ready = 1'($urandom);
        @(negedge clk);
        chk("resp_wait", lsu_send_valid, 1'b0);
      end
      mem_req_ready  = 1'b0;
      mem_rdata      = rdat;
      mem_resp_valid = 1'b1;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_rdata      = $urandom;
    end else begin
      chk("no_req", mem_req_valid, 1'b0);
    end

    last_result = result;
    last_fault  = lsu_fault;
    for (int i = 0; i <= send_stall; i++) begin
      if (i > 0) @(negedge clk);
      chk("send_valid", lsu_send_valid, 1'b1);
      chk("send_result", result, exp_result);
      chk("send_fault", lsu_fault, exp_fault);
      chk("send_pc", pc, exp_pc);
      chk("send_pcn", pc_next, exp_pcn);
      chk("send_misc", {19'b0, rd, csr_rd, wdOp, csrwdOp, reg_write_en, csreg_write_en, ecall},
          {19'b0, exp_misc});
      chk("send_busy", {30'b0, lsu_send_ready, mem_req_valid}, 32'h0);
      lsu_receive_ready = (i == send_stall);
      lsu_receive_valid = 1'($urandom);
    end
    @(negedge clk);
    lsu_receive_ready = 1'b0;
    lsu_receive_valid = 1'b0;
    chk("done_valid", lsu_send_valid, 1'b0);
    chk("done_ready", lsu_send_ready, 1'b1);
    $display("op kind=%0d addr=0x%08h result=0x%08h fault=%0b mem=%0b",
             kind, addr, last_result, last_fault, last_req_seen);
  endtask

  initial begin
    rst = 1'b1;
    lsu_receive_valid = 1'b0;  lsu_receive_ready = 1'b0;
    mem_req_ready = 1'b0;      mem_resp_valid = 1'b0;  mem_rdata = '0;
    scramble_inputs();
    #2 rst = 1'b0;
    #1 check_all_zero("reset_async");
    repeat (2) @(negedge clk);
    check_all_zero("reset_held");
    rst = 1'b1;
    @(negedge clk);

    run_op(K_ALU, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 0);
    chk("alu_result", last_result, 32'h0000_1234);
    chk("alu_nomem", last_req_seen, 1'b0);

    run_op(K_LB, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 1, 1, 0);
    chk("lb_addr", last_addr, 32'h8000_0000);
    chk("lb_result", last_result, 32'hFFFF_FF80);

    run_op(K_SH, 32'h8000_0002, 32'h0000_ABCD, 32'h0, 0, 0, 0);
    chk("sh_wdata", last_wdata, 32'hABCD_0000);
    chk("sh_wstrb", last_wstrb, 4'b1100);

    run_op(K_LHU, 32'h8000_0000, 32'h0, 32'h0000_F00D, 5, 2, 3);
    chk("lhu_result", last_result, 32'h0000_F00D);

    run_op(K_SRW, 32'h8000_0008, 32'h1122_3344, 32'h0, 0, 0, 1);

    run_op(K_LW, 32'h8000_0001, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    chk("lw_mis_fault", last_fault, MISALIGN_CHK);
    chk("lw_mis_req", last_req_seen, !MISALIGN_CHK);
    chk("lw_mis_addr", last_addr, MISALIGN_CHK ? 32'h0 : 32'h8000_0000);

    // Abandon a load in RESP with an asynchronous reset, then send a stale response.
    scramble_inputs();
    alu_result_input = 32'h8000_0010;  ren_input = 1'b1;  wen_input = 1'b0;
    rmask_input = 32'hFFFF_FFFF;  pc_input = 32'h8000_0010;  rd_input = 5'd7;
    lsu_receive_valid = 1'b1;
    @(negedge clk);
    lsu_receive_valid = 1'b0;
    chk("rst_inreq", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rst_inresp", mem_req_valid, 1'b0);
    #2 rst = 1'b0;
    #1 check_all_zero("rst_async");
    @(negedge clk);
    check_all_zero("rst_held");
    rst = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("late_valid", lsu_send_valid, 1'b0);
    chk("late_ready", lsu_send_ready, 1'b1);
    chk("late_result", result, 32'h0);

    for (int n = 0; n < 150; n++) begin
      run_op($urandom_range(0, 9), $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
